sprite_loader: RTL and testbench
================================

# sprite_loader

Receives a sprite image as a byte stream from the UART receiver and writes it, pixel by pixel, into the write port of the frog or car sprite memory. It is the writer for the 9-bit RRRGGGBBB sprite RAMs that the display path reads. It sits between the UART receiver and the two sprite memory instances. Sprites can then be reloaded at run time without re-synthesis.

## Interface
Parameters:
- TILE_SIZE, 32, sprite edge in pixels; image depth = TILE_SIZE*TILE_SIZE (1024), address width 10
- SYNC_BYTE, 8'hA5, frame start marker
- TIMEOUT_CYCLES, 2_500_000, maximum idle gap between bytes inside a frame (100 ms at 25 MHz)

Ports:
- i_Clk  in  1  system clock; sole clock domain
- i_Rst_L  in  1  reset, synchronous, active-low
- i_Rx_DV  in  1  one-cycle strobe: i_Rx_Byte valid
- i_Rx_Byte  in  8  received byte
- o_Wr_En  out  1  one-cycle write strobe to the selected sprite memory
- o_Wr_Sel  out  1  target memory: 0 = frog, 1 = car; held stable for the whole frame
- o_Wr_Addr  out  10  pixel address = row*TILE_SIZE + column
- o_Wr_Data  out  9  pixel {R[2:0],G[2:0],B[2:0]}
- o_Busy  out  1  high from the select byte until the frame ends or aborts
- o_Done  out  1  one-cycle pulse: frame complete, checksum good
- o_Error  out  1  one-cycle pulse: bad select, checksum mismatch or timeout

## Operation
Frame format, in order:
- SYNC_BYTE
- select byte: 8'h00 = frog, 8'h01 = car
- 1024 pixels, two bytes each: high byte bit0 = pixel[8] (bits 7:1 ignored), then low byte = pixel[7:0]
- checksum byte = XOR of all 2048 pixel bytes

States:
- IDLE: bytes other than SYNC_BYTE are discarded. On SYNC_BYTE go to SELECT.
- SELECT:
  - 00 or 01: latch o_Wr_Sel, clear address and checksum, set o_Busy, go to PIX_HI.
  - Any other value: pulse o_Error, go to IDLE.
- PIX_HI: latch bit0, XOR the byte into the checksum, go to PIX_LO.
- PIX_LO:
  - Drive o_Wr_Data = {hi_bit0, byte} and pulse o_Wr_En at the current address, then XOR the byte into the checksum.
  - If address = 1023, go to CHECK; otherwise increment the address and go to PIX_HI.
- CHECK:
  - Byte equals the running checksum: pulse o_Done.
  - Otherwise: pulse o_Error.
  - In both cases clear o_Busy and go to IDLE.
- Pixels already written are never rolled back; o_Error only flags a bad image.
- Inactivity timer:
  - Runs in SELECT, PIX_HI, PIX_LO and CHECK.
  - Cleared on every i_Rx_DV and on every state entry.
  - When it reaches TIMEOUT_CYCLES-1 with no byte, pulse o_Error, clear o_Busy and go to IDLE.
- SYNC_BYTE received mid-frame is treated as data, not as a resynchronisation.

## Timing
- All outputs are registered.
- Reset values: o_Wr_En=0, o_Wr_Sel=0, o_Wr_Addr=0, o_Wr_Data=0, o_Busy=0, o_Done=0, o_Error=0; state IDLE, checksum 0, timer 0.
- Reset asserted mid-frame: all of the above on the next edge. No further write is issued, and any write strobe in flight is dropped.
- Write latency: o_Wr_En, o_Wr_Addr and o_Wr_Data are valid in the cycle after the i_Rx_DV of the low byte, for exactly one cycle.
- o_Wr_Addr is held until the next write. It increments in the cycle after o_Wr_En, so it never changes while o_Wr_En is high.
- o_Busy rises the cycle after the select-byte strobe.
- o_Done or o_Error pulses the cycle after the checksum strobe, or the cycle after the timeout; o_Busy falls in that same cycle.
- i_Rx_DV strobes are at least 2 cycles apart (UART guarantee). The block must still accept back-to-back strobes on consecutive cycles.
- The timeout and a byte arriving on the same cycle: the byte wins and the timer clears.
- Address arithmetic is 10-bit and never wraps within a frame; CHECK is entered at 1023.

## Structure
- Shared package sprite_pkg holds:
  - SYNC_BYTE
  - SEL_FROG = 8'h00, SEL_CAR = 8'h01
  - the 9-bit pixel field slices R = [8:6], G = [5:3], B = [2:0]
  - TILE_SIZE and the derived SPRITE_DEPTH
  - the state enum
- The pixel slices must match those used by the display path.
- One sub-module: load_timeout, a loadable down-counter with clear and an expiry pulse, parameterised by TIMEOUT_CYCLES.

## Test plan
- Full frog frame, pixel n = n[8:0], correct checksum -> 1024 writes, addr 0..1023, data = addr, o_Wr_Sel=0; o_Done one cycle after the checksum strobe; o_Error stays 0.
- Car frame with the checksum byte XOR 8'h01 -> all 1024 writes issued with o_Wr_Sel=1; o_Error pulses once; o_Done stays 0.
- Bytes 8'h3C, 8'h00 in IDLE, then 8'hA5 with select 8'h02 -> no writes; o_Error pulses after the select byte; next valid frame loads normally.
- Stream stops after 10 pixels (TIMEOUT_CYCLES=100 for the sim) -> 10 writes; o_Error exactly 100 cycles after the last strobe; state IDLE; o_Busy=0.
- i_Rst_L low for 1 cycle after pixel 500 -> all outputs 0 on the next edge; a new frame restarts at addr 0.
- High byte 8'hFF, low byte 8'h12 -> o_Wr_Data = 9'h112.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants and types for the sprite RAM writer and the display path.
package sprite_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] SEL_FROG  = 8'h00;
    localparam logic [7:0] SEL_CAR   = 8'h01;

    localparam int TILE_SIZE    = 32;
    localparam int SPRITE_DEPTH = TILE_SIZE * TILE_SIZE;
    localparam int PIX_W        = 9;

    // RRRGGGBBB slices, shared with the display path
    localparam int PIX_R_MSB = 8;
    localparam int PIX_R_LSB = 6;
    localparam int PIX_G_MSB = 5;
    localparam int PIX_G_LSB = 3;
    localparam int PIX_B_MSB = 2;
    localparam int PIX_B_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_PIX_HI,
        ST_PIX_LO,
        ST_CHECK
    } state_e;

endpackage

// File: rtl/load_timeout.sv
// load_timeout: loadable down-counter; expires after TIMEOUT_CYCLES running cycles without a clear.
module load_timeout #(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Clr,
    input  logic i_Run,
    output logic o_Expire
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L)
            cnt_q <= '0;
        else if (i_Clr)
            cnt_q <= W'(TIMEOUT_CYCLES - 1);
        else if (i_Run && cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    // a clear in the same cycle means a byte arrived, which beats the timeout
    assign o_Expire = i_Run && !i_Clr && cnt_q == '0;

endmodule

// File: rtl/sprite_loader.sv
// sprite_loader: parses UART sprite frames and writes 9-bit pixels into the frog or car sprite RAM.
module sprite_loader #(
    parameter int          TILE_SIZE      = sprite_pkg::TILE_SIZE,
    parameter logic [7:0]  SYNC_BYTE      = sprite_pkg::SYNC_BYTE,
    parameter int          TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                                  i_Clk,
    input  logic                                  i_Rst_L,
    input  logic                                  i_Rx_DV,
    input  logic [7:0]                            i_Rx_Byte,
    output logic                                  o_Wr_En,
    output logic                                  o_Wr_Sel,
    output logic [$clog2(TILE_SIZE*TILE_SIZE)-1:0] o_Wr_Addr,
    output logic [8:0]                            o_Wr_Data,
    output logic                                  o_Busy,
    output logic                                  o_Done,
    output logic                                  o_Error
);

    import sprite_pkg::*;

    localparam int            AW   = $clog2(TILE_SIZE * TILE_SIZE);
    localparam logic [AW-1:0] LAST = AW'(TILE_SIZE * TILE_SIZE - 1);

    state_e     state_q;
    logic       hi_q;
    logic [7:0] csum_q;
    logic       expire;

    load_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_Clr    (i_Rx_DV),
        .i_Run    (state_q != ST_IDLE),
        .o_Expire (expire)
    );

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q   <= ST_IDLE;
            hi_q      <= 1'b0;
            csum_q    <= '0;
            o_Wr_En   <= 1'b0;
            o_Wr_Sel  <= 1'b0;
            o_Wr_Addr <= '0;
            o_Wr_Data <= '0;
            o_Busy    <= 1'b0;
            o_Done    <= 1'b0;
            o_Error   <= 1'b0;
        end else begin
            o_Wr_En <= 1'b0;
            o_Done  <= 1'b0;
            o_Error <= 1'b0;
            // address advances the cycle after a write so it is stable during the strobe
            if (o_Wr_En && o_Wr_Addr != LAST)
                o_Wr_Addr <= o_Wr_Addr + 1'b1;
            if (expire) begin
                state_q <= ST_IDLE;
                o_Busy  <= 1'b0;
                o_Error <= 1'b1;
            end else if (i_Rx_DV) begin
                case (state_q)
                    ST_IDLE: begin
                        if (i_Rx_Byte == SYNC_BYTE)
                            state_q <= ST_SELECT;
                    end
                    ST_SELECT: begin
                        if (i_Rx_Byte == SEL_FROG || i_Rx_Byte == SEL_CAR) begin
                            o_Wr_Sel  <= i_Rx_Byte[0];
                            o_Wr_Addr <= '0;
                            csum_q    <= '0;
                            o_Busy    <= 1'b1;
                            state_q   <= ST_PIX_HI;
                        end else begin
                            o_Error <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_PIX_HI: begin
                        hi_q    <= i_Rx_Byte[0];
                        csum_q  <= csum_q ^ i_Rx_Byte;
                        state_q <= ST_PIX_LO;
                    end
                    ST_PIX_LO: begin
                        o_Wr_En   <= 1'b1;
                        o_Wr_Data <= {hi_q, i_Rx_Byte};
                        csum_q    <= csum_q ^ i_Rx_Byte;
                        state_q   <= (o_Wr_Addr == LAST) ? ST_CHECK : ST_PIX_HI;
                    end
                    ST_CHECK: begin
                        o_Done  <= (i_Rx_Byte == csum_q);
                        o_Error <= (i_Rx_Byte != csum_q);
                        o_Busy  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_loader.sv
// tb_sprite_loader: directed frames against sprite_loader with a write scoreboard.
module tb_sprite_loader;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       wr_en, wr_sel, busy, done, error;
    logic [9:0] wr_addr;
    logic [8:0] wr_data;

    int n_tests = 0;
    int n_fail  = 0;

    int         wr_cnt, bad_cnt, done_cnt, err_cnt;
    logic [8:0] first_data;
    logic [8:0] exp_mem [1024];
    logic       exp_sel;
    logic       post_done, post_err, post_busy, post_wr_en, sel_busy;

    always #5 clk = ~clk;

    sprite_loader #(
        .TILE_SIZE      (32),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .i_Clk     (clk),
        .i_Rst_L   (rst_l),
        .i_Rx_DV   (rx_dv),
        .i_Rx_Byte (rx_byte),
        .o_Wr_En   (wr_en),
        .o_Wr_Sel  (wr_sel),
        .o_Wr_Addr (wr_addr),
        .o_Wr_Data (wr_data),
        .o_Busy    (busy),
        .o_Done    (done),
        .o_Error   (error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            if (wr_cnt == 0)
                first_data = wr_data;
            if (wr_addr != 10'(wr_cnt) || wr_data != exp_mem[wr_addr] || wr_sel != exp_sel)
                bad_cnt++;
            wr_cnt++;
        end
        if (done)
            done_cnt++;
        if (error)
            err_cnt++;
    end

    task automatic clear_counts();
        wr_cnt = 0;
        bad_cnt = 0;
        done_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit b2b);
        rx_dv = 1'b1;
        rx_byte = b;
        @(negedge clk);
        post_done = done;
        post_err = error;
        post_busy = busy;
        post_wr_en = wr_en;
        rx_dv = 1'b0;
        if (!b2b)
            @(negedge clk);
    endtask

    function automatic logic [8:0] pix(input int mode, input int n);
        if (mode == 1)
            return 9'(n * 37 + 5);
        if (mode == 2)
            return (n == 0) ? 9'h112 : ~9'(n);
        return 9'(n);
    endfunction

    task automatic send_frame(input logic [7:0] sel, input int mode, input int npix,
                              input logic [7:0] cs_xor, input bit b2b);
        logic [7:0] cs;
        logic [7:0] hi;
        logic [8:0] p;
        cs = 8'h00;
        exp_sel = sel[0];
        send_byte(8'hA5, b2b);
        send_byte(sel, b2b);
        sel_busy = post_busy;
        for (int i = 0; i < npix; i++) begin
            p = pix(mode, i);
            exp_mem[i] = p;
            hi = (mode == 2) ? {7'h7F, p[8]} : {7'h00, p[8]};
            cs = cs ^ hi ^ p[7:0];
            send_byte(hi, b2b);
            send_byte(p[7:0], b2b);
        end
        if (npix == 1024)
            send_byte(cs ^ cs_xor, b2b);
    endtask

    initial begin
        int cyc;
        clear_counts();
        repeat (3) @(negedge clk);
        check("rst_wr_en", {31'd0, wr_en}, 0);
        check("rst_wr_sel", {31'd0, wr_sel}, 0);
        check("rst_wr_addr", {22'd0, wr_addr}, 0);
        check("rst_wr_data", {23'd0, wr_data}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_error", {31'd0, error}, 0);
        rst_l = 1'b1;
        @(negedge clk);

        clear_counts();
        send_frame(8'h00, 0, 1024, 8'h00, 1'b0);
        check("frog_busy_after_sel", {31'd0, sel_busy}, 1);
        check("frog_writes", wr_cnt, 1024);
        check("frog_bad_writes", bad_cnt, 0);
        check("frog_done_pulse", {31'd0, post_done}, 1);
        check("frog_busy_end", {31'd0, post_busy}, 0);
        check("frog_addr_held", {22'd0, wr_addr}, 1023);
        @(negedge clk);
        check("frog_done_one_cycle", {31'd0, done}, 0);
        check("frog_errors", err_cnt, 0);

        clear_counts();
        send_frame(8'h01, 1, 1024, 8'h01, 1'b1);
        @(negedge clk);
        check("car_writes", wr_cnt, 1024);
        check("car_bad_writes", bad_cnt, 0);
        check("car_error_pulse", {31'd0, post_err}, 1);
        check("car_error_count", err_cnt, 1);
        check("car_done_count", done_cnt, 0);

        clear_counts();
        send_byte(8'h3C, 1'b0);
        send_byte(8'h00, 1'b0);
        check("idle_no_error", {31'd0, post_err}, 0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        check("badsel_error", {31'd0, post_err}, 1);
        check("badsel_busy", {31'd0, busy}, 0);
        check("badsel_writes", wr_cnt, 0);
        clear_counts();
        send_frame(8'h00, 2, 1024, 8'h00, 1'b0);
        check("reload_writes", wr_cnt, 1024);
        check("reload_bad_writes", bad_cnt, 0);
        check("hi_ff_lo_12_data", {23'd0, first_data}, 32'h112);
        check("reload_done", {31'd0, post_done}, 1);

        clear_counts();
        send_frame(8'h01, 0, 10, 8'h00, 1'b0);
        cyc = 0;
        while (!error && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_cycles", cyc + 1, 100);
        check("timeout_writes", wr_cnt, 10);
        check("timeout_busy", {31'd0, busy}, 0);
        check("timeout_addr_held", {22'd0, wr_addr}, 10);
        @(negedge clk);
        check("timeout_error_count", err_cnt, 1);

        clear_counts();
        send_frame(8'h01, 0, 500, 8'h00, 1'b0);
        exp_mem[500] = 9'h0AB;
        send_byte(8'h00, 1'b0);
        rx_dv = 1'b1;
        rx_byte = 8'hAB;
        rst_l = 1'b0;
        @(negedge clk);
        rx_dv = 1'b0;
        check("midrst_wr_en", {31'd0, wr_en}, 0);
        check("midrst_wr_sel", {31'd0, wr_sel}, 0);
        check("midrst_wr_addr", {22'd0, wr_addr}, 0);
        check("midrst_wr_data", {23'd0, wr_data}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        rst_l = 1'b1;
        @(negedge clk);
        check("midrst_writes", wr_cnt, 500);
        clear_counts();
        send_frame(8'h00, 0, 1024, 8'h00, 1'b0);
        check("restart_writes", wr_cnt, 1024);
        check("restart_bad_writes", bad_cnt, 0);
        check("restart_done", {31'd0, post_done}, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
